// File: rtl/vga_timing_gen_if.sv
// Raster bundle produced by vga_timing_gen and sampled by sprite/background blocks.
// rgb_test is carried only when VGA_TESTPAT_EN is defined.
interface vga_timing_gen_if #(
  parameter int CORDW = 10
);
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;
  logic             frame_end;
`ifdef VGA_TESTPAT_EN
  logic [11:0]      rgb_test;

  modport master (output sx, sy, de, hsync, vsync, line_start, frame_start, frame_end, rgb_test);
  modport slave  (input  sx, sy, de, hsync, vsync, line_start, frame_start, frame_end, rgb_test);
`else
  modport master (output sx, sy, de, hsync, vsync, line_start, frame_start, frame_end);
  modport slave  (input  sx, sy, de, hsync, vsync, line_start, frame_start, frame_end);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: sx/sy counters with registered sync, de and strobes.
// Define VGA_TESTPAT_EN to add the registered 8-bar colour test pattern on rgb_test.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CORDW    = 10
) (
  input  logic             clk_pix,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] ONE     = CORDW'(1);
  localparam logic [CORDW-1:0] H_LAST  = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST  = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT   = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT   = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_BEG  = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END  = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_BEG  = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END  = CORDW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] H_ALAST = CORDW'(H_ACTIVE - 1);
  localparam logic [CORDW-1:0] V_ALAST = CORDW'(V_ACTIVE - 1);

  logic [CORDW-1:0] sx_q, sy_q, sx_n, sy_n;
  logic de_q, hsync_q, vsync_q, ls_q, fs_q, fe_q;
  logic de_n, hs_act_n, vs_act_n, ls_n, fs_n, fe_n;

  // Outputs decode the next counter values so they register alongside sx/sy.
  always_comb begin
    sx_n = sx_q + ONE;
    sy_n = sy_q;
    if (sx_q == H_LAST) begin
      sx_n = '0;
      sy_n = (sy_q == V_LAST) ? '0 : sy_q + ONE;
    end
    de_n     = (sx_n < H_ACT) && (sy_n < V_ACT);
    hs_act_n = (sx_n >= HS_BEG) && (sx_n < HS_END);
    vs_act_n = (sy_n >= VS_BEG) && (sy_n < VS_END);
    ls_n     = (sx_n == '0);
    fs_n     = (sx_n == '0) && (sy_n == '0);
    fe_n     = (sx_n == H_ALAST) && (sy_n == V_ALAST);
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      de_q    <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sx_q    <= sx_n;
      sy_q    <= sy_n;
      de_q    <= de_n;
      hsync_q <= hs_act_n ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs_act_n ? SYNC_POL : ~SYNC_POL;
      ls_q    <= ls_n;
      fs_q    <= fs_n;
      fe_q    <= fe_n;
    end
  end

  assign vga.sx          = sx_q;
  assign vga.sy          = sy_q;
  assign vga.de          = de_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_end   = fe_q;

`ifdef VGA_TESTPAT_EN
  localparam logic [CORDW-1:0] BAR_W = CORDW'(H_ACTIVE / 8);

  logic [2:0]  bar;
  logic [11:0] rgb_n, rgb_q;

  always_comb begin
    bar = 3'(sx_n / BAR_W);
    case (bar)
      3'd0:    rgb_n = 12'hFFF;
      3'd1:    rgb_n = 12'hFF0;
      3'd2:    rgb_n = 12'h0FF;
      3'd3:    rgb_n = 12'h0F0;
      3'd4:    rgb_n = 12'hF0F;
      3'd5:    rgb_n = 12'hF00;
      3'd6:    rgb_n = 12'h00F;
      default: rgb_n = 12'h000;
    endcase
    if (!de_n) rgb_n = 12'h000;
  end

  always_ff @(posedge clk_pix) begin
    if (rst) rgb_q <= 12'h000;
    else     rgb_q <= rgb_n;
  end

  assign vga.rgb_test = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken-timing instance under random resets plus a default 640x480 instance.
module tb_vga_timing_gen;

  localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
  localparam int S_VA = 8,  S_VFP = 1, S_VS = 2, S_VBP = 2;
  localparam int S_FRAME = 25 * 13;
  localparam int D_FRAME = 800 * 525;

  logic clk_pix = 1'b0;
  logic rst_s = 1'b1;
  logic rst_d = 1'b1;
  always #5 clk_pix = ~clk_pix;

  int errors = 0;
  int checks = 0;

  vga_timing_gen_if #(.CORDW(10)) s_if ();
  vga_timing_gen_if #(.CORDW(10)) d_if ();

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_POL(1'b0), .CORDW(10)
  ) u_small (.clk_pix(clk_pix), .rst(rst_s), .vga(s_if));

  vga_timing_gen u_dflt (.clk_pix(clk_pix), .rst(rst_d), .vga(d_if));

  typedef struct packed {
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic        fe;
    logic [11:0] rgb;
  } exp_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] bar_colour(input int b);
    case (b)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Reference: position is simply the cycle index within the frame since reset release.
  function automatic exp_t model(input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input bit in_rst, input int idx);
    int ht, vt, x, y;
    exp_t e;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    e = '0;
    if (in_rst) begin
      e.sx = 10'(ht - 1);
      e.sy = 10'(vt - 1);
      e.hs = 1'b1;
      e.vs = 1'b1;
      return e;
    end
    x = idx % ht;
    y = idx / ht;
    e.sx  = 10'(x);
    e.sy  = 10'(y);
    e.de  = (x < ha) && (y < va);
    e.hs  = !((x >= ha + hfp) && (x < ha + hfp + hsw));
    e.vs  = !((y >= va + vfp) && (y < va + vfp + vsw));
    e.ls  = (x == 0);
    e.fs  = (idx == 0);
    e.fe  = (x == ha - 1) && (y == va - 1);
    e.rgb = e.de ? bar_colour(x / (ha / 8)) : 12'h000;
    return e;
  endfunction

  bit s_valid = 0, s_rst_st = 1, d_rst_st = 1;
  int s_idx = 0, d_idx = 0;

  always @(posedge clk_pix) begin
    s_valid <= 1'b1;
    if (rst_s) begin
      s_rst_st <= 1'b1;
      s_idx    <= 0;
    end else begin
      s_rst_st <= 1'b0;
      s_idx    <= s_rst_st ? 0 : (s_idx + 1) % S_FRAME;
    end
    if (rst_d) begin
      d_rst_st <= 1'b1;
      d_idx    <= 0;
    end else begin
      d_rst_st <= 1'b0;
      d_idx    <= d_rst_st ? 0 : (d_idx + 1) % D_FRAME;
    end
  end

  int s_cyc = 0, s_last_fs = -1, s_vs_cnt = 0, s_fe_cnt = 0;
  int d_hs_low = 0, d_de_cnt = 0;

  always @(negedge clk_pix) begin
    exp_t es, ed;
    if (s_valid) begin
      es = model(S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, s_rst_st, s_idx);
      ed = model(640, 16, 96, 48, 480, 10, 2, 33, d_rst_st, d_idx);
      chk("s_sx", int'(s_if.sx), int'(es.sx));
      chk("s_sy", int'(s_if.sy), int'(es.sy));
      chk("s_de", int'(s_if.de), int'(es.de));
      chk("s_hsync", int'(s_if.hsync), int'(es.hs));
      chk("s_vsync", int'(s_if.vsync), int'(es.vs));
      chk("s_line_start", int'(s_if.line_start), int'(es.ls));
      chk("s_frame_start", int'(s_if.frame_start), int'(es.fs));
      chk("s_frame_end", int'(s_if.frame_end), int'(es.fe));
      chk("d_sx", int'(d_if.sx), int'(ed.sx));
      chk("d_sy", int'(d_if.sy), int'(ed.sy));
      chk("d_de", int'(d_if.de), int'(ed.de));
      chk("d_hsync", int'(d_if.hsync), int'(ed.hs));
      chk("d_vsync", int'(d_if.vsync), int'(ed.vs));
      chk("d_line_start", int'(d_if.line_start), int'(ed.ls));
      chk("d_frame_start", int'(d_if.frame_start), int'(ed.fs));
      chk("d_frame_end", int'(d_if.frame_end), int'(ed.fe));
`ifdef VGA_TESTPAT_EN
      chk("s_rgb", int'(s_if.rgb_test), int'(es.rgb));
      chk("d_rgb", int'(d_if.rgb_test), int'(ed.rgb));
      if (!s_rst_st) begin
        if (s_idx == 2 * 25 + 0)  chk("s_pat_0_2",  int'(s_if.rgb_test), 'hFFF);
        if (s_idx == 2 * 25 + 2)  chk("s_pat_2_2",  int'(s_if.rgb_test), 'hFF0);
        if (s_idx == 2 * 25 + 15) chk("s_pat_15_2", int'(s_if.rgb_test), 'h000);
        if (s_idx == 2 * 25 + 20) chk("s_pat_20_2", int'(s_if.rgb_test), 'h000);
        if (s_idx == 9 * 25 + 1)  chk("s_pat_1_9",  int'(s_if.rgb_test), 'h000);
      end
      if (!d_rst_st) begin
        if (d_idx == 3 * 800 + 0)   chk("d_pat_0_3",   int'(d_if.rgb_test), 'hFFF);
        if (d_idx == 3 * 800 + 80)  chk("d_pat_80_3",  int'(d_if.rgb_test), 'hFF0);
        if (d_idx == 3 * 800 + 639) chk("d_pat_639_3", int'(d_if.rgb_test), 'h000);
        if (d_idx == 3 * 800 + 700) chk("d_pat_700_3", int'(d_if.rgb_test), 'h000);
      end
`endif
      // Frame period and vsync width only measured across frames with no reset inside.
      s_cyc++;
      if (s_rst_st) s_last_fs = -1;
      if (s_if.frame_start) begin
        if (s_last_fs >= 0) begin
          chk("s_fs_period", s_cyc - s_last_fs, 325);
          chk("s_vsync_cycles", s_vs_cnt, 50);
        end
        s_last_fs = s_cyc;
        s_vs_cnt  = 0;
      end
      if (!s_if.vsync) s_vs_cnt++;
      if (s_if.frame_end) s_fe_cnt++;
      if (!d_rst_st && d_idx < 800) begin
        if (!d_if.hsync) d_hs_low++;
        if (d_if.de) d_de_cnt++;
        if (d_idx == 799) begin
          chk("d_line_hsync_cycles", d_hs_low, 96);
          chk("d_line_de_cycles", d_de_cnt, 640);
        end
      end
    end
  end

  initial begin
    int fe_base;
    int k;
    rst_s = 1'b1;
    rst_d = 1'b1;
    repeat (5) @(posedge clk_pix);
    @(negedge clk_pix);
    chk("rst_sx", int'(s_if.sx), 24);
    chk("rst_sy", int'(s_if.sy), 12);
    chk("rst_d_sx", int'(d_if.sx), 799);
    chk("rst_d_sy", int'(d_if.sy), 524);
    chk("rst_hsync", int'(d_if.hsync), 1);
    chk("rst_vsync", int'(d_if.vsync), 1);
    @(posedge clk_pix);
    #1 rst_s = 1'b0; rst_d = 1'b0;
    @(posedge clk_pix);
    @(negedge clk_pix);
    chk("first_sx", int'(s_if.sx), 0);
    chk("first_sy", int'(s_if.sy), 0);
    chk("first_de", int'(s_if.de), 1);
    chk("first_ls", int'(s_if.line_start), 1);
    chk("first_fs", int'(s_if.frame_start), 1);
    @(negedge clk_pix);
    chk("second_sx", int'(d_if.sx), 1);
    chk("second_ls", int'(d_if.line_start), 0);
    chk("second_fs", int'(d_if.frame_start), 0);

    fe_base = s_fe_cnt;
    repeat (3 * S_FRAME) @(negedge clk_pix);
    chk("fe_count_3_frames", s_fe_cnt - fe_base, 3);

    k = 0;
    while (!(s_if.sx == 10'd7 && s_if.sy == 10'd5) && k < 1000) begin
      @(negedge clk_pix);
      k++;
    end
    chk("wait_mid_frame", int'(k < 1000), 1);
    rst_s = 1'b1;
    @(posedge clk_pix);
    #1 rst_s = 1'b0;
    @(negedge clk_pix);
    chk("midrst_sx", int'(s_if.sx), 24);
    chk("midrst_sy", int'(s_if.sy), 12);
    chk("midrst_strobes", int'({s_if.line_start, s_if.frame_start, s_if.frame_end}), 0);
    @(negedge clk_pix);
    chk("resume_sx", int'(s_if.sx), 0);
    chk("resume_sy", int'(s_if.sy), 0);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(1, 120)) @(posedge clk_pix);
      #1 rst_s = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk_pix);
      #1 rst_s = 1'b0;
    end
    repeat (2 * S_FRAME + 5) @(posedge clk_pix);
    @(negedge clk_pix);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
